mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the single-cycle mem_req/mem_write/mem_addr/mem_wdata request interface driven by our sequencer-generated compute blocks (matmul and similar).
- Every cycle with mem_req=1 is one complete transaction; the initiator has no ready signal, so the responder always accepts.
- Backs a word-addressed internal array, returns read data on mem_rdata/mem_rdata_vld after a fixed latency, and exposes error and traffic counters for verification and debug.

Parameters:
MEM_AW, 16, request address width (word address)
MEM_DW, 32, data width
DEPTH_AW, 10, implemented storage depth is 2**DEPTH_AW words; requires DEPTH_AW <= MEM_AW
RD_LAT, 2, cycles from read request to mem_rdata_vld; legal range 1..4
CNT_W, 32, width of the statistics counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; synchronous, active-high
mem_req  in  1  transaction valid this cycle
mem_write  in  1  1=write, 0=read; qualified by mem_req
mem_addr  in  MEM_AW  word address
mem_wdata  in  MEM_DW  write data
mem_rdata_vld  out  1  one-cycle pulse per read response
mem_rdata  out  MEM_DW  read data; valid only when mem_rdata_vld=1
mem_err  out  1  pulse marking a rejected transaction
busy  out  1  high while the post-reset clear sweep runs
wr_count  out  CNT_W  accepted writes, saturating
rd_count  out  CNT_W  accepted reads, saturating
err_count  out  CNT_W  rejected transactions, saturating

Behaviour:
- Reset (synchronous, rst=1 at a clock edge):
  - mem_rdata_vld=0, mem_rdata=0, mem_err=0, all counters=0, busy=1.
  - Read pipeline flushed: reads in flight are discarded and produce no response after reset.
  - FSM enters CLEAR.
- FSM states: CLEAR -> READY.
  - CLEAR: sweep index ptr runs 0..2**DEPTH_AW-1, writing 0 to one word per cycle; busy=1.
  - Leave CLEAR after the write to the last word. busy falls on the edge after the last clear write, so the sweep takes exactly 2**DEPTH_AW cycles.
  - READY: serve requests indefinitely; only rst returns the FSM to CLEAR.
- A request is accepted only when the FSM is in READY and mem_addr[MEM_AW-1:DEPTH_AW]==0. The storage index is mem_addr[DEPTH_AW-1:0].
- Accepted write:
  - Array updated at the request edge.
  - wr_count+1.
  - No response on the read channel.
- Accepted read:
  - Array sampled at the request edge.
  - mem_rdata_vld=1 and mem_rdata=data exactly RD_LAT cycles after the request cycle.
  - rd_count+1.
- Rejected transaction (out of range, or any request while busy):
  - Write: dropped; array unchanged. mem_err pulses one cycle after the request.
  - Read: mem_rdata_vld pulses at the normal RD_LAT slot with mem_rdata=0 and mem_err=1 in the same cycle.
  - err_count+1. The operation's normal counter is not incremented.
- Read-after-write:
  - A read in cycle N+1 of an address written in cycle N returns the new data.
  - Back-to-back reads issue one per cycle and respond in order, one per cycle.
- mem_wdata is ignored for reads; mem_write and mem_addr are ignored when mem_req=0.
- Counters saturate at all-ones and never wrap.
- Outside response cycles, mem_rdata holds 0.

Decomposition:
- Shared package mem_if_pkg:
  - request/response widths
  - RD_LAT limits
  - FSM state encoding (CLEAR, READY)
  - the rejected-read data value (0)
- One natural sub-module, mem_rd_pipe: an RD_LAT-deep shift register carrying {vld, err, data}, with synchronous flush on rst.
- Storage array, FSM and counters stay in mem_responder.

Test Plan:
1. Reset with DEPTH_AW=4 -> busy=1 for exactly 16 cycles then 0; read of addr 0..15 each returns 0; no mem_err.
2. After CLEAR, write addr 5 = 32'hA5A5_0001, read addr 5 the next cycle -> mem_rdata_vld with 32'hA5A5_0001 exactly RD_LAT=2 cycles after the read; wr_count=1, rd_count=1.
3. Four back-to-back reads of addr 1,2,3,1 (preloaded 11,22,33) -> four consecutive vld pulses with data 11,22,33,11, in order.
4. With DEPTH_AW=4, write addr 16'h0010 then read addr 16'h0010:
   - write dropped; mem_err pulses one cycle after the write request;
   - read returns vld with data 0 and mem_err=1;
   - err_count=2; addr 0 unchanged.
5. Request during CLEAR (write addr 3 = 7) -> rejected, err_count=1; after busy falls, addr 3 reads 0.
6. Issue a read, assert rst one cycle later -> no mem_rdata_vld ever appears for that read; counters read 0; busy=1.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the mem_responder slice: default widths, read
// latency limits, FSM state encoding and the data value returned by a
// rejected read.
package mem_if_pkg;

  localparam int MEM_AW_DEF   = 16;
  localparam int MEM_DW_DEF   = 32;
  localparam int DEPTH_AW_DEF = 10;
  localparam int RD_LAT_DEF   = 2;
  localparam int CNT_W_DEF    = 32;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  // Rejected reads still answer in their normal slot, carrying this value.
  localparam int unsigned REJ_DATA = 0;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // Keeps the read pipeline depth inside the supported latency window.
  function automatic int clamp_lat(input int lat);
    if (lat < RD_LAT_MIN) return RD_LAT_MIN;
    if (lat > RD_LAT_MAX) return RD_LAT_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Single-cycle request bus between a compute block (master) and the memory
// responder (slave). There is no ready: every mem_req cycle is a transaction.
interface mem_responder_if #(
  parameter int MEM_AW = 16,
  parameter int MEM_DW = 32
);

  logic              mem_req;
  logic              mem_write;
  logic [MEM_AW-1:0] mem_addr;
  logic [MEM_DW-1:0] mem_wdata;
  logic              mem_rdata_vld;
  logic [MEM_DW-1:0] mem_rdata;
  logic              mem_err;

  modport master (
    output mem_req, mem_write, mem_addr, mem_wdata,
    input  mem_rdata_vld, mem_rdata, mem_err
  );

  modport slave (
    input  mem_req, mem_write, mem_addr, mem_wdata,
    output mem_rdata_vld, mem_rdata, mem_err
  );

endinterface

// File: rtl/mem_responder_rd_pipe.sv
// Fixed-latency read response pipeline. Each stage carries {vld, err, data};
// a synchronous reset flushes every stage so in-flight reads never answer.
module mem_rd_pipe #(
  parameter int DW  = 32,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_vld,
  input  logic          in_err,
  input  logic [DW-1:0] in_data,
  output logic          out_vld,
  output logic          out_err,
  output logic [DW-1:0] out_data
);

  logic          vld_q  [LAT];
  logic          err_q  [LAT];
  logic [DW-1:0] data_q [LAT];

  // Shift the response one stage per cycle; flush everything on reset.
  // NOTE: non-blocking assignments make each stage load its neighbour's
  // pre-edge value, so the loop order cannot collapse the pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        vld_q[i]  <= 1'b0;
        err_q[i]  <= 1'b0;
        data_q[i] <= '0;
      end
    end else begin
      vld_q[0]  <= in_vld;
      err_q[0]  <= in_err;
      data_q[0] <= in_data;
      for (int i = 1; i < LAT; i++) begin
        vld_q[i]  <= vld_q[i-1];
        err_q[i]  <= err_q[i-1];
        data_q[i] <= data_q[i-1];
      end
    end
  end

  assign out_vld  = vld_q[LAT-1];
  assign out_err  = err_q[LAT-1];
  assign out_data = data_q[LAT-1];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: word-addressed storage zeroed by a post-reset
// sweep, fixed-latency read responses, error flagging for out-of-range or
// early requests, and saturating traffic counters.
module mem_responder
  import mem_if_pkg::*;
#(
  parameter int MEM_AW   = MEM_AW_DEF,
  parameter int MEM_DW   = MEM_DW_DEF,
  parameter int DEPTH_AW = DEPTH_AW_DEF,
  parameter int RD_LAT   = RD_LAT_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  mem_responder_if.slave   bus,
  output logic             busy,
  output logic [CNT_W-1:0] wr_count,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int DEPTH    = 2**DEPTH_AW;
  localparam int PIPE_LAT = clamp_lat(RD_LAT);

  state_t              state;
  logic [DEPTH_AW-1:0] ptr;
  logic [MEM_DW-1:0]   mem [DEPTH];

  logic [DEPTH_AW-1:0] idx;
  logic                in_range;
  logic                accept;
  logic                wr_acc;
  logic                rd_acc;
  logic                rejected;
  logic                wr_err_q;

  logic                pipe_in_vld;
  logic                pipe_in_err;
  logic [MEM_DW-1:0]   pipe_in_data;
  logic                pipe_out_vld;
  logic                pipe_out_err;
  logic [MEM_DW-1:0]   pipe_out_data;

  // Request decode: only READY state and an address inside the array qualify.
  assign idx      = bus.mem_addr[DEPTH_AW-1:0];
  assign in_range = (bus.mem_addr >> DEPTH_AW) == '0;
  assign accept   = (state == ST_READY) && in_range;
  assign wr_acc   = bus.mem_req &&  bus.mem_write && accept;
  assign rd_acc   = bus.mem_req && !bus.mem_write && accept;
  assign rejected = bus.mem_req && !accept;

  // Storage writes: the clear sweep owns the array until READY.
  // NOTE: the array has no reset; the CLEAR sweep zeroes it instead, which
  // keeps it mappable to RAM.
  always_ff @(posedge clk) begin
    if (!rst && state == ST_CLEAR) begin
      mem[ptr] <= '0;
    end else if (!rst && wr_acc) begin
      mem[idx] <= bus.mem_wdata;
    end
  end

  // Control FSM: sweep every word once after reset, then serve forever.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_CLEAR;
      ptr   <= '0;
      busy  <= 1'b1;
    end else begin
      unique case (state)
        ST_CLEAR: begin
          ptr <= ptr + DEPTH_AW'(1);
          if (&ptr) begin
            state <= ST_READY;
            busy  <= 1'b0;
          end
        end
        ST_READY: begin
        end
      endcase
    end
  end

  // Saturating traffic counters and the one-cycle rejected-write flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count  <= '0;
      rd_count  <= '0;
      err_count <= '0;
      wr_err_q  <= 1'b0;
    end else begin
      wr_err_q <= rejected && bus.mem_write;
      if (wr_acc   && wr_count  != '1) wr_count  <= wr_count  + CNT_W'(1);
      if (rd_acc   && rd_count  != '1) rd_count  <= rd_count  + CNT_W'(1);
      if (rejected && err_count != '1) err_count <= err_count + CNT_W'(1);
    end
  end

  // Every read, accepted or not, enters the pipe so it answers in its slot.
  assign pipe_in_vld  = bus.mem_req && !bus.mem_write;
  assign pipe_in_err  = pipe_in_vld && !accept;
  assign pipe_in_data = rd_acc ? mem[idx] : MEM_DW'(REJ_DATA);

  mem_rd_pipe #(
    .DW  (MEM_DW),
    .LAT (PIPE_LAT)
  ) u_rd_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (pipe_in_vld),
    .in_err   (pipe_in_err),
    .in_data  (pipe_in_data),
    .out_vld  (pipe_out_vld),
    .out_err  (pipe_out_err),
    .out_data (pipe_out_data)
  );

  assign bus.mem_rdata_vld = pipe_out_vld;
  assign bus.mem_rdata     = pipe_out_data;
  assign bus.mem_err       = pipe_out_err || wr_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder with a 16-word array and RD_LAT=2.
// Each request pushes its expected response (cycle, vld, err, data); a
// negedge monitor pops and compares, and expects silence otherwise.
module tb_mem_responder;

  localparam int MEM_AW   = 16;
  localparam int MEM_DW   = 32;
  localparam int DEPTH_AW = 4;
  localparam int RD_LAT   = 2;
  localparam int CNT_W    = 32;

  typedef struct {
    int                due;
    logic              vld;
    logic              err;
    logic [MEM_DW-1:0] data;
  } sb_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             busy;
  logic [CNT_W-1:0] wr_count;
  logic [CNT_W-1:0] rd_count;
  logic [CNT_W-1:0] err_count;

  mem_responder_if #(.MEM_AW(MEM_AW), .MEM_DW(MEM_DW)) bus ();

  mem_responder #(
    .MEM_AW   (MEM_AW),
    .MEM_DW   (MEM_DW),
    .DEPTH_AW (DEPTH_AW),
    .RD_LAT   (RD_LAT),
    .CNT_W    (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .busy      (busy),
    .wr_count  (wr_count),
    .rd_count  (rd_count),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  int               cyc = 0;
  int               n_checks = 0;
  int               n_pass = 0;
  bit               mon_on = 1'b0;
  bit               exp_ready = 1'b0;
  logic [CNT_W-1:0] exp_wr, exp_rd, exp_err;
  logic [MEM_DW-1:0] mdl [16];
  sb_t              sbq [$];

  always @(posedge clk) cyc++;

  // Monitor: merge every expectation due this cycle and compare the outputs.
  always @(negedge clk) begin : monitor
    sb_t               e;
    logic              ev, ee;
    logic [MEM_DW-1:0] ed;
    if (mon_on) begin
      ev = 1'b0; ee = 1'b0; ed = '0;
      while (sbq.size() > 0 && sbq[0].due <= cyc) begin
        e = sbq.pop_front();
        if (e.due == cyc) begin
          ev = ev | e.vld;
          ee = ee | e.err;
          if (e.vld) ed = e.data;
        end
      end
      n_checks++;
      if (bus.mem_rdata_vld !== ev || bus.mem_err !== ee || bus.mem_rdata !== ed)
        $display("FAIL resp cyc=%0d got vld=%b err=%b data=%h expected vld=%b err=%b data=%h",
                 cyc, bus.mem_rdata_vld, bus.mem_err, bus.mem_rdata, ev, ee, ed);
      else
        n_pass++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // Idle cycles with random, unqualified address/write/data on the bus.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.mem_req   = 1'b0;
      bus.mem_write = 1'($urandom);
      bus.mem_addr  = 16'($urandom);
      bus.mem_wdata = $urandom;
    end
  endtask

  // One request cycle; the bench model decides acceptance and the outcome.
  task automatic do_req(input bit wr, input logic [MEM_AW-1:0] addr, input logic [MEM_DW-1:0] wd);
    bit acc;
    @(posedge clk); #1;
    bus.mem_req   = 1'b1;
    bus.mem_write = wr;
    bus.mem_addr  = addr;
    bus.mem_wdata = wd;
    acc = exp_ready && (addr[15:4] == 12'h000);
    if (wr) begin
      if (acc) begin
        mdl[addr[3:0]] = wd;
        exp_wr++;
      end else begin
        exp_err++;
        sbq.push_back('{due: cyc + 1, vld: 1'b0, err: 1'b1, data: '0});
      end
    end else begin
      if (acc) exp_rd++;
      else     exp_err++;
      sbq.push_back('{due: cyc + RD_LAT, vld: 1'b1, err: !acc,
                      data: acc ? mdl[addr[3:0]] : '0});
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst         = 1'b1;
    bus.mem_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    sbq.delete();
    exp_ready = 1'b0;
    exp_wr = '0; exp_rd = '0; exp_err = '0;
    for (int i = 0; i < 16; i++) mdl[i] = '0;
  endtask

  // Counts negedges with busy high, bounded at 40.
  task automatic wait_ready(output int n);
    n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    exp_ready = 1'b1;
  endtask

  task automatic drain_and_count(input string tag);
    idle(RD_LAT + 2);
    n_checks++;
    if (sbq.size() !== 0) $display("FAIL %s drain got %0d pending expected 0", tag, sbq.size());
    else n_pass++;
    n_checks++;
    if (wr_count !== exp_wr || rd_count !== exp_rd || err_count !== exp_err)
      $display("FAIL %s counters got wr=%0d rd=%0d err=%0d expected wr=%0d rd=%0d err=%0d",
               tag, wr_count, rd_count, err_count, exp_wr, exp_rd, exp_err);
    else n_pass++;
  endtask

  task automatic test_reset();
    int n;
    do_reset();
    mon_on = 1'b1;
    n_checks++;
    if (busy !== 1'b1 || wr_count !== '0 || rd_count !== '0 || err_count !== '0 ||
        bus.mem_rdata_vld !== 1'b0 || bus.mem_rdata !== '0 || bus.mem_err !== 1'b0)
      $display("FAIL reset_state got busy=%b wr=%0d rd=%0d err=%0d vld=%b data=%h merr=%b expected busy=1 all else 0",
               busy, wr_count, rd_count, err_count, bus.mem_rdata_vld, bus.mem_rdata, bus.mem_err);
    else n_pass++;
    wait_ready(n);
    n_checks++;
    if (n !== 16) $display("FAIL busy_cycles got %0d expected 16", n);
    else n_pass++;
    for (int a = 0; a < 16; a++) do_req(1'b0, 16'(a), 32'($urandom));
    drain_and_count("reset_reads");
  endtask

  task automatic test_raw();
    int n;
    do_reset();
    wait_ready(n);
    do_req(1'b1, 16'd5, 32'hA5A5_0001);
    do_req(1'b0, 16'd5, 32'h0);
    drain_and_count("raw");
    n_checks++;
    if (wr_count !== 32'd1 || rd_count !== 32'd1)
      $display("FAIL raw_counts got wr=%0d rd=%0d expected wr=1 rd=1", wr_count, rd_count);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_req(1'b1, 16'd1, 32'd11);
    do_req(1'b1, 16'd2, 32'd22);
    do_req(1'b1, 16'd3, 32'd33);
    do_req(1'b0, 16'd1, 32'hFFFF_FFFF);
    do_req(1'b0, 16'd2, 32'hFFFF_FFFF);
    do_req(1'b0, 16'd3, 32'hFFFF_FFFF);
    do_req(1'b0, 16'd1, 32'hFFFF_FFFF);
    drain_and_count("back_to_back");
  endtask

  task automatic test_out_of_range();
    logic [CNT_W-1:0] err0;
    err0 = err_count;
    do_req(1'b1, 16'h0010, 32'hDEAD_BEEF);
    idle(1);
    do_req(1'b0, 16'h0010, 32'h0);
    do_req(1'b0, 16'h0000, 32'h0);
    do_req(1'b1, 16'h8003, 32'h1234_5678);
    do_req(1'b0, 16'h0003, 32'h0);
    drain_and_count("out_of_range");
    n_checks++;
    if (err_count - err0 !== 32'd3)
      $display("FAIL oor_err_delta got %0d expected 3", err_count - err0);
    else n_pass++;
  endtask

  task automatic test_clear_reject();
    int n;
    do_reset();
    do_req(1'b1, 16'd3, 32'd7);
    idle(1);
    wait_ready(n);
    n_checks++;
    if (n >= 40) $display("FAIL clear_timeout got %0d busy cycles expected under 40", n);
    else n_pass++;
    do_req(1'b0, 16'd3, 32'h0);
    drain_and_count("clear_reject");
    n_checks++;
    if (err_count !== 32'd1) $display("FAIL clear_err got %0d expected 1", err_count);
    else n_pass++;
  endtask

  task automatic test_reset_flush();
    do_req(1'b1, 16'd2, 32'h0BAD_F00D);
    do_req(1'b0, 16'd2, 32'h0);
    do_reset();
    n_checks++;
    if (busy !== 1'b1 || wr_count !== '0 || rd_count !== '0 || err_count !== '0)
      $display("FAIL flush_state got busy=%b wr=%0d rd=%0d err=%0d expected busy=1 counters 0",
               busy, wr_count, rd_count, err_count);
    else n_pass++;
    drain_and_count("reset_flush");
  endtask

  initial begin
    bus.mem_req   = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    exp_wr = '0; exp_rd = '0; exp_err = '0;
    repeat (2) @(posedge clk);
    test_reset();
    test_raw();
    test_back_to_back();
    test_out_of_range();
    test_clear_reject();
    test_reset_flush();
    idle(3);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
